// File: rtl/i2c_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to I2C command bridge.
package i2c_bridge_pkg;

  // Command word layout as seen by the downstream I2C master
  typedef struct packed {
    logic [6:0]  dev_addr;
    logic        rw;
    logic [15:0] payload;
  } i2c_cmd_t;

  // Register offsets
  localparam logic [3:0] OFF_CMD    = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_RDBYTE = 4'h8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Accepted device-id window when the id check is built in
  localparam logic [6:0] DEV_ID_MIN = 7'd1;
  localparam logic [6:0] DEV_ID_MAX = 7'd9;

  // Bridge FSM states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESENT   = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Small synchronous command FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module i2c_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, no reset needed: contents are only read when count > 0
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/axi_lite_i2c_cmd_bridge.sv
// AXI4-Lite slave queueing I2C command words and handing them one at a time
// to the downstream I2C master; captures returned read bytes.
// Optional build macro: I2C_DEV_ID_CHECK_EN (reject dev_addr outside 1..9,
// sticky bad_id in STATUS[8]).
module axi_lite_i2c_cmd_bridge
  import i2c_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int AXI_ADDR_W = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [AXI_ADDR_W-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [AXI_ADDR_W-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  I2C_MASTER_TRIGGER,
  output logic [DATA_WIDTH-1:0] ADDR_DATA_OUT,
  output logic                  VALID_ADDR_DATA_OUT,
  input  logic                  VALID_ADDR_DATA_OUT_ACK,
  input  logic                  VALID_ADDR_DATA_OUT_ACK_VALID,
  input  logic [7:0]            RDATA_OUT,
  input  logic                  RDATA_VALID,
  output logic                  RDATA_VALID_ACK
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_pop, push;
  logic [CW-1:0]         fifo_count;
  logic                  wr_hs, rd_hs, wr_cmd, id_ok, bad_id;
  logic                  rbyte_set, done_seen, data_seen, xfer_done;
  logic [7:0]            rd_byte;
  logic                  rd_flag;
  logic [31:0]           status_word, rd_word;
  logic [1:0]            rd_resp;
  logic                  unused_bits;

  assign unused_bits = ^WDATA[31:DATA_WIDTH];

  // Reset: asynchronous assert, release synchronised to ACLK
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Handshakes are gated by reset so every output is 0 while in reset
  assign wr_hs   = rst_n & AWVALID & WVALID & ~BVALID;
  assign AWREADY = wr_hs;
  assign WREADY  = wr_hs;
  assign ARREADY = rst_n & ~RVALID;
  assign rd_hs   = ARVALID & ARREADY;

  assign wr_cmd = (AWADDR == AXI_ADDR_W'(OFF_CMD));
`ifdef I2C_DEV_ID_CHECK_EN
  assign id_ok = (i2c_cmd_t'(WDATA[23:0]).dev_addr >= DEV_ID_MIN) &&
                 (i2c_cmd_t'(WDATA[23:0]).dev_addr <= DEV_ID_MAX);
`else
  assign id_ok = 1'b1;
`endif
  assign push = wr_hs & wr_cmd & ~fifo_full & id_ok;

  i2c_cmd_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ACLK),
    .rst_n (rst_n),
    .push  (push),
    .wdata (WDATA[DATA_WIDTH-1:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Write response: OKAY only when the command was actually queued
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      BVALID <= 1'b0;
      BRESP  <= AXI_RESP_OKAY;
    end else if (wr_hs) begin
      BVALID <= 1'b1;
      BRESP  <= push ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (BREADY) begin
      BVALID <= 1'b0;
    end
  end

`ifdef I2C_DEV_ID_CHECK_EN
  // Sticky bad device id; a new offence in the same cycle as a STATUS read wins
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n)                                         bad_id <= 1'b0;
    else if (wr_hs && wr_cmd && !id_ok)                 bad_id <= 1'b1;
    else if (rd_hs && ARADDR == AXI_ADDR_W'(OFF_STATUS)) bad_id <= 1'b0;
  end
`else
  assign bad_id = 1'b0;
`endif

  assign status_word = {23'b0, bad_id, 4'(fifo_count), rd_flag,
                        I2C_MASTER_TRIGGER, fifo_empty, fifo_full};

  // Read data mux; CMD is write-only so it reads as unmapped
  always_comb begin
    rd_word = '0;
    rd_resp = AXI_RESP_OKAY;
    case (ARADDR)
      AXI_ADDR_W'(OFF_STATUS): rd_word = status_word;
      AXI_ADDR_W'(OFF_RDBYTE): rd_word = {24'b0, rd_byte};
      default:                 rd_resp = AXI_RESP_SLVERR;
    endcase
  end

  // Read response register, held until RREADY
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= AXI_RESP_OKAY;
    end else if (rd_hs) begin
      RVALID <= 1'b1;
      RDATA  <= rd_word;
      RRESP  <= rd_resp;
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end

  // Read-byte capture; a held RDATA_VALID is consumed once per ack pulse
  assign rbyte_set = RDATA_VALID & ~RDATA_VALID_ACK;
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_byte         <= '0;
      rd_flag         <= 1'b0;
      RDATA_VALID_ACK <= 1'b0;
    end else begin
      RDATA_VALID_ACK <= rbyte_set;
      if (rbyte_set) rd_byte <= RDATA_OUT;
      if (rbyte_set)                                       rd_flag <= 1'b1;
      else if (rd_hs && ARADDR == AXI_ADDR_W'(OFF_RDBYTE)) rd_flag <= 1'b0;
    end
  end

  // A transfer finishes once done has pulsed and, for reads, data has arrived;
  // either may come first so both are remembered
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;
  assign xfer_done = (VALID_ADDR_DATA_OUT_ACK_VALID | done_seen) &
                     (~ADDR_DATA_OUT[16] | data_seen | RDATA_VALID);

  // Downstream presentation FSM
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ADDR_DATA_OUT <= '0;
      done_seen     <= 1'b0;
      data_seen     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_seen <= 1'b0;
          data_seen <= 1'b0;
          if (!fifo_empty) begin
            ADDR_DATA_OUT <= fifo_rdata;
            state         <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          data_seen <= data_seen | RDATA_VALID;
          if (VALID_ADDR_DATA_OUT_ACK) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          done_seen <= done_seen | VALID_ADDR_DATA_OUT_ACK_VALID;
          data_seen <= data_seen | RDATA_VALID;
          if (xfer_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign VALID_ADDR_DATA_OUT = (state == ST_PRESENT);
  assign I2C_MASTER_TRIGGER  = (state != ST_IDLE);

endmodule

// File: tb/tb_axi_lite_i2c_cmd_bridge.sv
// Directed bench for axi_lite_i2c_cmd_bridge: register table plus
// hand-written sequences for the multi-cycle downstream and reset cases.
module tb_axi_lite_i2c_cmd_bridge;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic        I2C_MASTER_TRIGGER, VALID_ADDR_DATA_OUT, RDATA_VALID_ACK;
  logic [23:0] ADDR_DATA_OUT;
  logic        VALID_ADDR_DATA_OUT_ACK, VALID_ADDR_DATA_OUT_ACK_VALID, RDATA_VALID;
  logic [7:0]  RDATA_OUT;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  axi_lite_i2c_cmd_bridge dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .I2C_MASTER_TRIGGER(I2C_MASTER_TRIGGER), .ADDR_DATA_OUT(ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT(VALID_ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT_ACK(VALID_ADDR_DATA_OUT_ACK),
    .VALID_ADDR_DATA_OUT_ACK_VALID(VALID_ADDR_DATA_OUT_ACK_VALID),
    .RDATA_OUT(RDATA_OUT), .RDATA_VALID(RDATA_VALID),
    .RDATA_VALID_ACK(RDATA_VALID_ACK)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    resp = 2'bxx;
    AWADDR = a; WDATA = d; AWVALID = 1; WVALID = 1; BREADY = 1; #1;
    while (!AWREADY && n < 20) begin tick(); n++; end
    if (!AWREADY) begin
      timeout("aw_ready");
      AWVALID = 0; WVALID = 0; BREADY = 0;
      return;
    end
    tick();
    AWVALID = 0; WVALID = 0;
    if (!BVALID) timeout("bvalid");
    else resp = BRESP;
    tick();
    BREADY = 0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    d = 'x; resp = 2'bxx;
    ARADDR = a; ARVALID = 1; RREADY = 1; #1;
    while (!ARREADY && n < 20) begin tick(); n++; end
    if (!ARREADY) begin
      timeout("ar_ready");
      ARVALID = 0; RREADY = 0;
      return;
    end
    tick();
    ARVALID = 0;
    if (!RVALID) timeout("rvalid");
    else begin d = RDATA; resp = RRESP; end
    tick();
    RREADY = 0;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    logic [31:0] d; logic [1:0] r;
    axi_read(4'h4, d, r);
    check(name, d, exp);
  endtask

  task automatic pulse_ack();
    VALID_ADDR_DATA_OUT_ACK = 1; tick(); VALID_ADDR_DATA_OUT_ACK = 0;
  endtask

  task automatic pulse_done();
    VALID_ADDR_DATA_OUT_ACK_VALID = 1; tick(); VALID_ADDR_DATA_OUT_ACK_VALID = 0;
  endtask

  function automatic logic [31:0] out_bits();
    return {18'b0, AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP,
            I2C_MASTER_TRIGGER, VALID_ADDR_DATA_OUT, RDATA_VALID_ACK};
  endfunction

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    // Register-level vectors with no downstream activity: fill the FIFO
    // behind a presented command, overflow it, then touch an unmapped offset.
    vecs[0]  = '{1, 4'h0, 32'h020001, OKAY,   0,        "fill_w1"};
    vecs[1]  = '{1, 4'h0, 32'h020002, OKAY,   0,        "fill_w2"};
    vecs[2]  = '{1, 4'h0, 32'h020003, OKAY,   0,        "fill_w3"};
    vecs[3]  = '{1, 4'h0, 32'h020004, OKAY,   0,        "fill_w4"};
    vecs[4]  = '{1, 4'h0, 32'h020005, OKAY,   0,        "fill_w5"};
    vecs[5]  = '{0, 4'h4, 0,          OKAY,   32'h45,   "status_full"};
    vecs[6]  = '{1, 4'h0, 32'h020006, SLVERR, 0,        "overflow_w6"};
    vecs[7]  = '{0, 4'h4, 0,          OKAY,   32'h45,   "status_after_ovf"};
    vecs[8]  = '{1, 4'hC, 32'h020007, SLVERR, 0,        "unmapped_wr"};
    vecs[9]  = '{0, 4'hC, 0,          SLVERR, 32'h0,    "unmapped_rd"};
    vecs[10] = '{0, 4'h4, 0,          OKAY,   32'h45,   "status_after_unmapped"};
    vecs[11] = '{0, 4'h8, 0,          OKAY,   32'h3C,   "rdbyte_kept"};

    ARESETn = 0; AWADDR = 0; ARADDR = 0; AWVALID = 0; WVALID = 0; BREADY = 0;
    ARVALID = 0; RREADY = 0; WDATA = 0; VALID_ADDR_DATA_OUT_ACK = 0;
    VALID_ADDR_DATA_OUT_ACK_VALID = 0; RDATA_VALID = 0; RDATA_OUT = 0;

    // Reset state
    repeat (3) tick();
    check("rst_outputs", out_bits(), 0);
    check("rst_addr_data", {8'b0, ADDR_DATA_OUT}, 0);
    check("rst_rdata", RDATA, 0);
    ARESETn = 1;
    repeat (3) tick();
    rd_status("rst_status", 32'h02);

    // Single write command through the downstream handshake
    axi_write(4'h0, 32'h020A5C, r);
    check("w1_bresp", r, OKAY);
    check("w1_valid", VALID_ADDR_DATA_OUT, 1);
    check("w1_trigger", I2C_MASTER_TRIGGER, 1);
    check("w1_addr_data", ADDR_DATA_OUT, 24'h020A5C);
    repeat (2) tick();
    check("w1_hold", {VALID_ADDR_DATA_OUT, ADDR_DATA_OUT}, {1'b1, 24'h020A5C});
    pulse_ack();
    check("w1_ack_valid_low", VALID_ADDR_DATA_OUT, 0);
    check("w1_ack_trig_high", I2C_MASTER_TRIGGER, 1);
    pulse_done();
    check("w1_done_trig_low", I2C_MASTER_TRIGGER, 0);
    rd_status("w1_status_idle", 32'h02);

    // Read command: done arrives before the byte, so the FSM must keep waiting
    axi_write(4'h0, 32'h030010, r);
    check("rd_cmd_bresp", r, OKAY);
    check("rd_cmd_addr", ADDR_DATA_OUT, 24'h030010);
    pulse_ack();
    pulse_done();
    check("rd_wait_for_byte", I2C_MASTER_TRIGGER, 1);
    RDATA_OUT = 8'hA7; RDATA_VALID = 1; tick(); RDATA_VALID = 0;
    check("rd_ack_pulse", RDATA_VALID_ACK, 1);
    check("rd_trig_low", I2C_MASTER_TRIGGER, 0);
    tick();
    check("rd_ack_one_cycle", RDATA_VALID_ACK, 0);
    rd_status("rd_flag_set", 32'h0A);
    axi_read(4'h8, d, r);
    check("rdbyte_val", d, 32'hA7);
    rd_status("rd_flag_clr", 32'h02);

    // RDBYTE read coincident with a new byte: old byte returned, flag stays set
    ARADDR = 4'h8; ARVALID = 1; RREADY = 1; RDATA_OUT = 8'h3C; RDATA_VALID = 1;
    tick();
    ARVALID = 0; RDATA_VALID = 0;
    check("coinc_old_byte", RDATA, 32'hA7);
    tick();
    RREADY = 0;
    rd_status("coinc_flag_wins", 32'h0A);
    axi_read(4'h8, d, r);
    check("coinc_new_byte", d, 32'h3C);

    // Table-driven register vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, r);
        check(vecs[i].name, r, vecs[i].resp);
      end else begin
        axi_read(vecs[i].addr, d, r);
        check(vecs[i].name, {d[29:0], r}, {vecs[i].rdata[29:0], vecs[i].resp});
      end
    end
    check("fill_presented", ADDR_DATA_OUT, 24'h020001);

    // Drain in order until the third command sits in WAIT_DONE with two queued
    for (int k = 1; k <= 2; k++) begin
      check($sformatf("drain_%0d", k), ADDR_DATA_OUT, 24'h020000 + k);
      pulse_ack();
      pulse_done();
      tick();
    end
    check("drain_3", {VALID_ADDR_DATA_OUT, ADDR_DATA_OUT}, {1'b1, 24'h020003});
    pulse_ack();
    rd_status("pre_reset_status", 32'h24);

    // Reset mid-operation
    ARESETn = 0; #1;
    check("midrst_outputs", out_bits(), 0);
    check("midrst_addr_data", {8'b0, ADDR_DATA_OUT}, 0);
    repeat (2) tick();
    ARESETn = 1;
    repeat (3) tick();
    rd_status("midrst_status", 32'h02);
    repeat (5) tick();
    check("midrst_no_trigger", I2C_MASTER_TRIGGER, 0);
    axi_write(4'h0, 32'h020777, r);
    check("post_rst_present", {VALID_ADDR_DATA_OUT, ADDR_DATA_OUT}, {1'b1, 24'h020777});

`ifdef I2C_DEV_ID_CHECK_EN
    axi_write(4'h0, 32'h140000, r);
    check("badid_slverr", r, SLVERR);
    rd_status("badid_sticky", 32'h106);
    rd_status("badid_cleared", 32'h006);
    axi_write(4'h0, 32'h120000, r);
    check("id9_okay", r, OKAY);
    rd_status("id9_queued", 32'h14);
`else
    axi_write(4'h0, 32'h140000, r);
    check("id10_okay", r, OKAY);
    rd_status("id10_queued", 32'h14);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_i2c_cmd_bridge.md
Name: axi_lite_i2c_cmd_bridge

Overview:
- AXI4-Lite slave that accepts I2C command words from the bus and queues them in a small FIFO.
- Presents one command at a time to the downstream I2C master on ADDR_DATA_OUT / VALID_ADDR_DATA_OUT and drives I2C_MASTER_TRIGGER.
- Captures returned read bytes (RDATA_OUT / RDATA_VALID) into a register readable over AXI.
- Sits directly upstream of the I2C master stage, in the ACLK domain.

Parameters:
- DATA_WIDTH, 24, command word width: {dev_addr[23:17], rw[16], mem_addr_data[15:0]}.
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- AXI_ADDR_W, 4, AXI-Lite address width.

Ports:
- ACLK  in  1  global clock.
- ARESETn  in  1  asynchronous active-low reset.
- AWADDR  in  AXI_ADDR_W  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  AXI_ADDR_W  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- I2C_MASTER_TRIGGER  out  1  high while a command is presented downstream.
- ADDR_DATA_OUT  out  DATA_WIDTH  command word to the I2C master.
- VALID_ADDR_DATA_OUT  out  1  command valid.
- VALID_ADDR_DATA_OUT_ACK  in  1  downstream accepted the command.
- VALID_ADDR_DATA_OUT_ACK_VALID  in  1  downstream transaction complete (one-cycle pulse).
- RDATA_OUT  in  8  read byte from the I2C master.
- RDATA_VALID  in  1  read byte valid.
- RDATA_VALID_ACK  out  1  read byte consumed.

Behaviour:
- Reset
  - Synchronous de-assertion through a 2-flop synchronizer internal to this block; assertion is asynchronous.
  - All outputs reset to 0. FIFO is empty, rd_byte = 0, rd_flag = 0, state = IDLE.
- Register map (offsets)
  - 0x0 CMD, write-only: WDATA[23:0] is pushed to the FIFO.
  - 0x4 STATUS, read-only: [0] fifo_full, [1] fifo_empty, [2] busy, [3] rd_flag, [7:4] fifo_count, rest 0.
  - 0x8 RDBYTE, read-only: [7:0] rd_byte. A read clears rd_flag.
- Write channel
  - AWREADY = WREADY = AWVALID & WVALID & !BVALID. AW and W are taken in the same cycle only.
  - Offset 0x0 with FIFO not full: push; BRESP = OKAY.
  - Offset 0x0 with FIFO full: no push; BRESP = SLVERR.
  - Any other offset: BRESP = SLVERR, no side effect.
  - BVALID rises the cycle after acceptance and is held until BREADY.
- Read channel
  - ARREADY = !RVALID.
  - RVALID rises the cycle after acceptance and is held until RREADY.
  - Unmapped offset: RDATA = 0, RRESP = SLVERR.
- Downstream FSM: IDLE -> PRESENT -> WAIT_DONE -> IDLE.
  - IDLE: if the FIFO is not empty, pop the head into the output register; go to PRESENT the next cycle.
  - PRESENT: VALID_ADDR_DATA_OUT = 1, I2C_MASTER_TRIGGER = 1, ADDR_DATA_OUT held stable. On VALID_ADDR_DATA_OUT_ACK, drop VALID and go to WAIT_DONE. TRIGGER stays high.
  - WAIT_DONE: on VALID_ADDR_DATA_OUT_ACK_VALID, drop TRIGGER and go to IDLE. If rw = 1 (read) and RDATA_VALID has not yet arrived, stay in WAIT_DONE until it does.
  - busy = (state != IDLE).
- Read return path
  - On RDATA_VALID, latch RDATA_OUT into rd_byte, set rd_flag, and pulse RDATA_VALID_ACK for one cycle.
  - A new RDATA_VALID overwrites rd_byte even if rd_flag is still set.
- Simultaneous events
  - Push and pop in the same cycle: count is unchanged, pointers wrap modulo FIFO_DEPTH.
  - An AXI read of RDBYTE in the same cycle as RDATA_VALID: the set wins; RDATA returns the old byte.
- Reset mid-operation: the FSM aborts to IDLE, the FIFO is flushed, and no trigger is driven.

Optional Feature:
- I2C_DEV_ID_CHECK_EN defined
  - A CMD write whose dev_addr (WDATA[23:17]) is outside 1..9 is not pushed and returns SLVERR.
  - STATUS[8] is a sticky bad_id flag, cleared by a read of STATUS.
- I2C_DEV_ID_CHECK_EN undefined: every dev_addr is accepted and STATUS[8] reads 0.

Decomposition:
- Package i2c_bridge_pkg:
  - i2c_cmd_t packed struct {dev_addr[6:0], rw, payload[15:0]}.
  - Register offset localparams.
  - AXI_RESP_OKAY / AXI_RESP_SLVERR.
  - DEV_ID_MIN = 1, DEV_ID_MAX = 9.
  - Bridge FSM state enum.
- Sub-module i2c_cmd_fifo: synchronous FIFO with push/pop/full/empty/count, same clock and reset.

Test Plan:
- Write 0x0 = 0x02_0A5C (dev 1, write) -> BRESP OKAY. One cycle later VALID_ADDR_DATA_OUT = 1 and ADDR_DATA_OUT = 0x020A5C. Ack -> VALID drops. ACK_VALID pulse -> TRIGGER drops and STATUS.busy = 0.
- Write 5 commands with no downstream ack (FIFO_DEPTH = 4) -> the first is popped into PRESENT. Writes 2-5 fill the FIFO (STATUS = full, count 4). A 6th write returns SLVERR and is not queued.
- Read command 0x03_0010 -> after ack, drive RDATA_OUT = 0xA7 with RDATA_VALID -> RDATA_VALID_ACK pulses one cycle. STATUS[3] = 1. Read 0x8 returns 0xA7, then STATUS[3] = 0.
- Write to offset 0xC and read offset 0xC -> SLVERR on both, with no FIFO or FSM change.
- Deassert ARESETn while in WAIT_DONE with 2 entries queued -> all outputs 0, STATUS reads empty after reset, and no trigger until a new write.
- With I2C_DEV_ID_CHECK_EN: write dev_addr 0x0A -> SLVERR, STATUS[8] = 1. Write dev_addr 0x09 -> OKAY and it is queued.
